// File: rtl/arm_pkg.sv
// Shared definitions for the byte-wide data-memory master.
// State encoding and word geometry.
package arm_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_LAST,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_byte_master.sv
// Byte-serial initiator for 32-bit loads/stores against a byte memory.
// Holds the pipeline via freeze while four byte beats are in flight.
module mem_byte_master
    import arm_pkg::*;
#(
    parameter int BIT_NUMBER = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mem_r_en,
    input  logic                                 mem_w_en,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [BYTES_PER_WORD*BIT_NUMBER-1:0] wdata,
    output logic [BYTES_PER_WORD*BIT_NUMBER-1:0] rdata,
    output logic                                 ready,
    output logic                                 freeze,
    output logic [ADDR_W-1:0]                    m_addr,
    output logic [BIT_NUMBER-1:0]                m_wdata,
    output logic                                 m_we,
    output logic                                 m_re,
    input  logic [BIT_NUMBER-1:0]                m_rdata
);

    localparam int WORD_W = BYTES_PER_WORD * BIT_NUMBER;
    localparam int BUF_W  = (BYTES_PER_WORD - 1) * BIT_NUMBER;

    mem_state_t        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BUF_W-1:0]  rbuf_q, rbuf_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [1:0]        prev_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    // read data arrives one cycle behind its strobe
    assign prev_lane = cnt_q - 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        ready   = 1'b0;
        m_we    = 1'b0;
        m_re    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        unique case (state_q)
            IDLE: begin
                ready = ~(mem_r_en | mem_w_en);
                if (mem_r_en | mem_w_en) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = mem_w_en ? WR : RD;
                end
            end
            WR: begin
                m_we    = 1'b1;
                m_addr  = addr_q + ADDR_W'(cnt_q);
                m_wdata = wdata_q[cnt_q*BIT_NUMBER +: BIT_NUMBER];
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = DONE;
            end
            RD: begin
                m_re   = 1'b1;
                m_addr = addr_q + ADDR_W'(cnt_q);
                if (cnt_q != 2'd0)
                    rbuf_d[prev_lane*BIT_NUMBER +: BIT_NUMBER] = m_rdata;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = RD_LAST;
            end
            RD_LAST: begin
                rdata_d = {m_rdata, rbuf_q};
                state_d = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata  = rdata_q;
    assign freeze = ~ready;

endmodule

// File: tb/tb_mem_byte_master.sv
// Scoreboard bench for mem_byte_master with a 1-cycle byte RAM.
// Driver pushes expectations; a negedge monitor pops on each ready pulse.
module tb_mem_byte_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready, freeze;
    logic [31:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic        m_we, m_re;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          nwe;
        int          nre;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ram[bit [31:0]];
    logic [7:0]  ref_mem[bit [31:0]];
    logic [31:0] model_rdata = '0;

    mem_byte_master #(.BIT_NUMBER(8), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .ready(ready), .freeze(freeze),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_we(m_we), .m_re(m_re), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (m_we) ram[m_addr] = m_wdata;
        if (m_re) m_rdata <= ram_rd(m_addr);
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    int busy = 0, we_n = 0, re_n = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy = 0; we_n = 0; re_n = 0;
        end else begin
            chk("freeze_inv", {31'd0, freeze}, {31'd0, ~ready});
            chk("strobe_excl", {31'd0, m_we & m_re}, 32'd0);
            if ((mem_r_en | mem_w_en) && !ready) begin
                busy++;
                we_n += int'(m_we);
                re_n += int'(m_re);
            end else if ((mem_r_en | mem_w_en) && ready) begin
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL sb_underflow: got ready pulse, required none");
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.rdata);
                    chk("latency", busy, e.lat);
                    chk("we_beats", we_n, e.nwe);
                    chk("re_beats", re_n, e.nre);
                end
                busy = 0; we_n = 0; re_n = 0;
            end
        end
    end

    task automatic issue(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        int   n;
        if (w) begin
            for (int k = 0; k < 4; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
            e.lat = 5; e.nwe = 4; e.nre = 0;
        end else begin
            for (int k = 0; k < 4; k++) model_rdata[8*k +: 8] = ref_rd(a + 32'(k));
            e.lat = 6; e.nwe = 0; e.nre = 4;
        end
        e.rdata = model_rdata;
        sb.push_back(e);
        mem_w_en = w; mem_r_en = r; addr = a; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 20);
        if (!ready) begin
            checks++; fails++;
            $display("FAIL timeout: got no ready after %0d cycles, required <= 7", n);
        end
        @(posedge clk); #1;
        mem_w_en = 1'b0; mem_r_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_r_en = 0; mem_w_en = 0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_strobes", {30'd0, m_we, m_re}, 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mwdata", {24'd0, m_wdata}, 32'd0);
        @(posedge clk); #1;

        issue(1, 0, 32'h400, 32'hDEADBEEF);
        chk("t1_b0", {24'd0, ram_rd(32'h400)}, 32'hEF);
        chk("t1_b1", {24'd0, ram_rd(32'h401)}, 32'hBE);
        chk("t1_b2", {24'd0, ram_rd(32'h402)}, 32'hAD);
        chk("t1_b3", {24'd0, ram_rd(32'h403)}, 32'hDE);

        issue(0, 1, 32'h400, 32'h0);
        chk("t2_rdata", rdata, 32'hDEADBEEF);

        issue(1, 0, 32'h401, 32'h11223344);
        issue(0, 1, 32'h400, 32'h0);
        chk("t3_rdata", rdata, 32'h223344EF);

        issue(1, 1, 32'h10, 32'h5);
        chk("t4_b0", {24'd0, ram_rd(32'h10)}, 32'h05);
        chk("t4_rdata", rdata, 32'h223344EF);

        mem_w_en = 1; addr = 32'h20; wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_w_en = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[32'h20] = 8'hDD; ref_mem[32'h21] = 8'hCC;
        model_rdata = '0;
        @(negedge clk);
        chk("t5_we", {31'd0, m_we}, 32'd0);
        chk("t5_ready", {31'd0, ready}, 32'd1);
        chk("t5_rdata", rdata, 32'd0);
        chk("t5_b20", {24'd0, ram_rd(32'h20)}, 32'hDD);
        chk("t5_b21", {24'd0, ram_rd(32'h21)}, 32'hCC);
        chk("t5_b22", {24'd0, ram_rd(32'h22)}, 32'h00);
        chk("t5_b23", {24'd0, ram_rd(32'h23)}, 32'h00);
        @(posedge clk); #1;

        issue(1, 0, 32'hFFFFFFFE, 32'hCAFEF00D);
        issue(0, 1, 32'hFFFFFFFE, 32'h0);
        chk("t6_bFE", {24'd0, ram_rd(32'hFFFFFFFE)}, 32'h0D);
        chk("t6_bFF", {24'd0, ram_rd(32'hFFFFFFFF)}, 32'hF0);
        chk("t6_b00", {24'd0, ram_rd(32'h0)}, 32'hFE);
        chk("t6_b01", {24'd0, ram_rd(32'h1)}, 32'hCA);
        chk("t6_rdata", rdata, 32'hCAFEF00D);

        for (int i = 0; i < 40; i++) begin
            int          op;
            int          gap;
            logic [31:0] a;
            op  = $urandom_range(0, 2);
            gap = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 15));
            else                           a = 32'h100 + 32'($urandom_range(0, 31));
            issue(op != 1, op != 0, a, $urandom);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        foreach (ref_mem[k]) chk("final_ram", {24'd0, ram_rd(k)}, {24'd0, ref_mem[k]});
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
